// File: rtl/wb_reg_slave.sv
// Wishbone classic-cycle register slave: control, W1C status, reload timer,
// software interrupt and scratch registers behind programmable wait states.
module wb_reg_slave #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  adr,
  input  logic [31:0] dat_i,
  input  logic        we,
  input  logic        stb,
  input  logic        cyc,
  output logic [31:0] dat_o,
  output logic        ack,
  output logic        intr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  word_q, word_d;
  logic        we_q, we_d;
  logic [31:0] wdat_q, wdat_d;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [1:0]  stat_q, stat_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] dat_o_q, dat_o_d;

  logic        req;
  logic        commit;
  logic [5:0]  c_word;
  logic        c_we;
  logic [31:0] c_wdat;
  logic        timer_set;
  logic        sw_set;
  logic [1:0]  w1c;
  logic [31:0] rdata;
  logic        unused_adr_bits;

  assign req             = cyc & stb;
  assign unused_adr_bits = ^adr[1:0];

  // Commit happens on the edge entering S_ACK; with no wait states that edge
  // is the sampling edge, so the live bus is used instead of the latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    commit  = 1'b0;
    c_word  = word_q;
    c_we    = we_q;
    c_wdat  = wdat_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          word_d = adr[7:2];
          we_d   = we;
          wdat_d = dat_i;
          c_word = adr[7:2];
          c_we   = we;
          c_wdat = dat_i;
          if (NO_WAIT) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    scratch_d = scratch_q;
    timer_set = 1'b0;
    sw_set    = 1'b0;
    w1c       = 2'b00;
    if (ctrl_q[0]) begin
      if (count_q == 32'd0) begin
        count_d   = load_q;
        timer_set = 1'b1;
      end else begin
        count_d = count_q - 32'd1;
      end
    end
    // A LOAD write overrides a reload on the same edge.
    if (commit && c_we) begin
      case (c_word)
        6'd0: ctrl_d = c_wdat[2:0];
        6'd1: w1c = c_wdat[1:0];
        6'd2: begin
          load_d  = c_wdat;
          count_d = c_wdat;
        end
        6'd4: sw_set = c_wdat[0];
        6'd5: scratch_d = c_wdat;
        default: ;
      endcase
    end
    stat_d = (stat_q & ~w1c) | {sw_set, timer_set};

    rdata = 32'd0;
    case (c_word)
      6'd0: rdata = {29'd0, ctrl_q};
      6'd1: rdata = {30'd0, stat_q};
      6'd2: rdata = load_q;
      6'd3: rdata = count_q;
      6'd5: rdata = scratch_q;
      default: rdata = 32'd0;
    endcase
    dat_o_d = (commit && !c_we) ? rdata : dat_o_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      word_q    <= 6'd0;
      we_q      <= 1'b0;
      wdat_q    <= 32'd0;
      ctrl_q    <= 3'd0;
      stat_q    <= 2'd0;
      load_q    <= 32'd0;
      count_q   <= 32'd0;
      scratch_q <= 32'd0;
      dat_o_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      we_q      <= we_d;
      wdat_q    <= wdat_d;
      ctrl_q    <= ctrl_d;
      stat_q    <= stat_d;
      load_q    <= load_d;
      count_q   <= count_d;
      scratch_q <= scratch_d;
      dat_o_q   <= dat_o_d;
    end
  end

  assign ack   = (state_q == S_ACK);
  assign dat_o = dat_o_q;
  assign intr  = |(stat_q & ctrl_q[2:1]);

endmodule
